// File: rtl/mant_scheduler.sv
// mant_scheduler: maintenance scheduler sitting upstream of the 8-bit
// maintenance-count register. Counts usage events, raises a maintenance
// alert at the usage limit, issues a one-cycle register enable on technician
// acknowledge, and latches out-of-service once the maintenance budget is spent.
module mant_scheduler #(
    parameter int USO_LIMITE = 10,
    parameter int MANT_MAX   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uso,
    input  logic       ack_mant,
    input  logic [7:0] mant_count,
    output logic       mant_enable,
    output logic [7:0] mant_data,
    output logic       alerta_mant,
    output logic       fuera_servicio,
    output logic [7:0] uso_count,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        OPERANDO       = 2'd0,
        ALERTA         = 2'd1,
        MANTENIMIENTO  = 2'd2,
        FUERA_SERVICIO = 2'd3
    } state_t;

    // Last usage count before the limit; the uso that arrives here trips the alert.
    localparam logic [7:0] USO_LAST   = 8'(USO_LIMITE - 1);
    // Budget compared on 9 bits so a register value of 255 cannot wrap to 0.
    localparam logic [8:0] MANT_MAX_9 = 9'(MANT_MAX);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] uso_count_r;
    logic [7:0] uso_count_nxt_s;
    logic [7:0] mant_data_r;
    logic [7:0] mant_data_nxt_s;
    logic       mant_enable_r;
    logic       alerta_mant_r;
    logic       fuera_servicio_r;
    logic       budget_spent_s;

    // Value the register will hold after this maintenance, compared against the budget.
    always_comb begin
        budget_spent_s = (({1'b0, mant_data_r} + 9'd1) >= MANT_MAX_9);
    end

    // Next-state and next-datapath decode; every state holds its values by default.
    always_comb begin
        state_nxt_s     = state_r;
        uso_count_nxt_s = uso_count_r;
        mant_data_nxt_s = mant_data_r;
        case (state_r)
            OPERANDO: begin
                if (uso) begin
                    uso_count_nxt_s = uso_count_r + 8'd1;
                    if (uso_count_r == USO_LAST) begin
                        state_nxt_s = ALERTA;
                    end else begin
                        state_nxt_s = OPERANDO;
                    end
                end else begin
                    uso_count_nxt_s = uso_count_r;
                end
            end
            ALERTA: begin
                // ack wins over a simultaneous uso; the usage event is dropped.
                if (ack_mant) begin
                    mant_data_nxt_s = mant_count;
                    state_nxt_s     = MANTENIMIENTO;
                end else begin
                    state_nxt_s     = ALERTA;
                end
            end
            MANTENIMIENTO: begin
                uso_count_nxt_s = 8'd0;
                if (budget_spent_s) begin
                    state_nxt_s = FUERA_SERVICIO;
                end else begin
                    state_nxt_s = OPERANDO;
                end
            end
            FUERA_SERVICIO: begin
                uso_count_nxt_s = 8'd0;
                state_nxt_s     = FUERA_SERVICIO;
            end
            default: begin
                uso_count_nxt_s = 8'd0;
                state_nxt_s     = OPERANDO;
            end
        endcase
    end

    // State, datapath and registered Moore flags; reset dominates all inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= OPERANDO;
            uso_count_r      <= 8'd0;
            mant_data_r      <= 8'd0;
            mant_enable_r    <= 1'b0;
            alerta_mant_r    <= 1'b0;
            fuera_servicio_r <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            uso_count_r      <= uso_count_nxt_s;
            mant_data_r      <= mant_data_nxt_s;
            mant_enable_r    <= (state_nxt_s == MANTENIMIENTO);
            alerta_mant_r    <= (state_nxt_s == ALERTA);
            fuera_servicio_r <= (state_nxt_s == FUERA_SERVICIO);
        end
    end

    assign mant_enable    = mant_enable_r;
    assign mant_data      = mant_data_r;
    assign alerta_mant    = alerta_mant_r;
    assign fuera_servicio = fuera_servicio_r;
    assign uso_count      = uso_count_r;
    assign estado         = state_r;

endmodule

// File: tb/tb_mant_scheduler.sv
// Testbench for mant_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against an event-level reference model. Includes a
// behavioural copy of the downstream maintenance-count register.
module tb_mant_scheduler;

    localparam int USO_LIMITE = 10;
    localparam int MANT_MAX   = 5;

    logic       clk;
    logic       reset;
    logic       uso;
    logic       ack_mant;
    logic [7:0] mant_count;
    logic       mant_enable;
    logic [7:0] mant_data;
    logic       alerta_mant;
    logic       fuera_servicio;
    logic [7:0] uso_count;
    logic [1:0] estado;

    logic       force_en;
    logic [7:0] force_val;
    logic [7:0] reg_q;

    int n_tests;
    int n_fail;

    // reference model state (spec state codes, plain integers)
    int m_st;
    int m_uso;
    int m_data;
    int m_reg;

    mant_scheduler #(.USO_LIMITE(USO_LIMITE), .MANT_MAX(MANT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .uso           (uso),
        .ack_mant      (ack_mant),
        .mant_count    (mant_count),
        .mant_enable   (mant_enable),
        .mant_data     (mant_data),
        .alerta_mant   (alerta_mant),
        .fuera_servicio(fuera_servicio),
        .uso_count     (uso_count),
        .estado        (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream maintenance-count register: shares reset, stores data+1 on enable
    always @(posedge clk) begin
        if (reset) reg_q <= 8'd0;
        else if (mant_enable) reg_q <= mant_data + 8'd1;
    end

    assign mant_count = force_en ? force_val : reg_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour at one clock edge, from the usage/maintenance rules.
    task automatic model_edge(input bit r, input bit u, input bit a, input int mc);
        if (r) begin
            m_st = 0; m_uso = 0; m_data = 0; m_reg = 0;
        end else begin
            if (m_st == 2) m_reg = (m_data + 1) % 256;
            if (m_st == 0) begin
                if (u) begin
                    m_uso = m_uso + 1;
                    if (m_uso == USO_LIMITE) m_st = 1;
                end
            end else if (m_st == 1) begin
                if (a) begin
                    m_data = mc;
                    m_st = 2;
                end
            end else if (m_st == 2) begin
                m_uso = 0;
                m_st = (m_data + 1 >= MANT_MAX) ? 3 : 0;
            end
        end
    endtask

    task automatic compare_all();
        check("estado",         32'(estado),         32'(m_st));
        check("uso_count",      32'(uso_count),      32'(m_uso));
        check("mant_data",      32'(mant_data),      32'(m_data));
        check("mant_enable",    32'(mant_enable),    32'(m_st == 2));
        check("alerta_mant",    32'(alerta_mant),    32'(m_st == 1));
        check("fuera_servicio", 32'(fuera_servicio), 32'(m_st == 3));
        check("register",       32'(reg_q),          32'(m_reg));
    endtask

    // one clock: drive after negedge, update model at posedge, sample #1 later
    task automatic cycle(input bit r, input bit u, input bit a);
        int mc;
        @(negedge clk);
        reset = r; uso = u; ack_mant = a;
        mc = force_en ? int'(force_val) : int'(reg_q);
        @(posedge clk);
        model_edge(r, u, a, mc);
        #1;
        compare_all();
    endtask

    task automatic uso_pulses(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_st = 0; m_uso = 0; m_data = 0; m_reg = 0;
        reset = 1'b1; uso = 1'b0; ack_mant = 1'b0;
        force_en = 1'b0; force_val = 8'd0;

        // reset state
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_uso", 32'(uso_count), 32'd0);

        // ack in OPERANDO is ignored
        cycle(1'b0, 1'b0, 1'b1);
        check("ack_op_estado", 32'(estado), 32'd0);
        check("ack_op_en", 32'(mant_enable), 32'd0);

        // count to alert
        for (int i = 1; i <= USO_LIMITE; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check("count_step", 32'(uso_count), 32'(i));
        end
        check("alert_estado", 32'(estado), 32'd1);
        check("alert_flag", 32'(alerta_mant), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        check("count_hold", 32'(uso_count), 32'd10);

        // maintenance handshake with register value 3
        force_en = 1'b1; force_val = 8'd3;
        cycle(1'b0, 1'b0, 1'b1);
        force_en = 1'b0;
        check("hs_en", 32'(mant_enable), 32'd1);
        check("hs_data", 32'(mant_data), 32'd3);
        check("hs_estado", 32'(estado), 32'd2);
        cycle(1'b0, 1'b0, 1'b0);
        check("hs_en_off", 32'(mant_enable), 32'd0);
        check("hs_back_op", 32'(estado), 32'd0);
        check("hs_uso_clr", 32'(uso_count), 32'd0);
        check("hs_reg", 32'(reg_q), 32'd4);

        // simultaneous uso+ack in ALERTA; register at 4 exhausts the budget
        uso_pulses(USO_LIMITE);
        cycle(1'b0, 1'b1, 1'b1);
        check("sim_estado", 32'(estado), 32'd2);
        check("sim_uso", 32'(uso_count), 32'd10);
        cycle(1'b0, 1'b0, 1'b0);
        check("fs_estado", 32'(estado), 32'd3);
        check("fs_flag", 32'(fuera_servicio), 32'd1);
        check("fs_reg", 32'(reg_q), 32'd5);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("fs_terminal", 32'(estado), 32'd3);
        end

        // reset during MANTENIMIENTO
        cycle(1'b1, 1'b0, 1'b0);
        uso_pulses(USO_LIMITE);
        cycle(1'b0, 1'b0, 1'b1);
        check("pre_rst_en", 32'(mant_enable), 32'd1);
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_mid_estado", 32'(estado), 32'd0);
        check("rst_mid_en", 32'(mant_enable), 32'd0);
        check("rst_mid_reg", 32'(reg_q), 32'd0);

        // reset with uso at uso_count 5
        uso_pulses(5);
        check("pre_rst_uso", 32'(uso_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b0);
        check("rst_uso_clr", 32'(uso_count), 32'd0);

        // full loop: five maintenances from reset
        for (int k = 1; k <= MANT_MAX; k++) begin
            uso_pulses(USO_LIMITE);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0);
            check("loop_reg", 32'(reg_q), 32'(k));
            check("loop_fs", 32'(fuera_servicio), 32'(k == MANT_MAX));
        end

        // randomized traffic with register feedback and occasional reset
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mant_scheduler.md
# mant_scheduler

Maintenance scheduler FSM that sits directly upstream of the 8-bit maintenance-count register. It counts usage events, raises a maintenance-due alert once a usage limit is reached, and on technician acknowledge issues a single-cycle enable with the current count so the register stores count+1. It reads the register's output back and latches the unit out of service once the maintenance budget is exhausted.

## Interface
Parameters:
- USO_LIMITE, 10: number of usage events between maintenances. Legal range 1..255.
- MANT_MAX, 5: number of maintenances allowed before the unit goes out of service. Legal range 1..255.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- uso  in  1  usage event; one event per cycle in which it is high.
- ack_mant  in  1  technician acknowledge of the maintenance alert.
- mant_count  in  8  current output of the maintenance-count register (feedback).
- mant_enable  out  1  enable for the maintenance-count register.
- mant_data  out  8  data for the maintenance-count register; the register stores mant_data+1.
- alerta_mant  out  1  maintenance due.
- fuera_servicio  out  1  unit out of service.
- uso_count  out  8  usage events counted since the last maintenance.
- estado  out  2  state code: 0=OPERANDO, 1=ALERTA, 2=MANTENIMIENTO, 3=FUERA_SERVICIO.

## Operation
- Moore FSM. Every output is registered.
- Reset (synchronous, evaluated at the clock edge) sets:
  - estado=OPERANDO.
  - uso_count=0, mant_data=0.
  - mant_enable=0, alerta_mant=0, fuera_servicio=0.
  - Reset has priority over every other input.
- OPERANDO:
  - On uso, uso_count increments by 1.
  - When uso arrives with uso_count==USO_LIMITE-1, uso_count becomes USO_LIMITE and the FSM moves to ALERTA.
  - ack_mant is ignored in this state.
- ALERTA:
  - alerta_mant=1 for the whole state.
  - uso is ignored; uso_count holds at USO_LIMITE.
  - On ack_mant: capture mant_data<=mant_count and move to MANTENIMIENTO.
  - If uso and ack_mant arrive together, ack_mant wins and the uso event is dropped.
- MANTENIMIENTO:
  - Lasts exactly one cycle, with mant_enable=1 and alerta_mant=0.
  - The next state is chosen by a 9-bit compare, mant_data+1 >= MANT_MAX (no 8-bit wrap):
    - If true: go to FUERA_SERVICIO.
    - If false: go to OPERANDO.
  - In both cases uso_count clears to 0.
  - uso and ack_mant are ignored.
- FUERA_SERVICIO:
  - fuera_servicio=1.
  - Terminal state; only reset leaves it.
  - uso and ack_mant are ignored; uso_count stays 0.
- mant_enable is high in MANTENIMIENTO only, never for more than 1 consecutive cycle.
- alerta_mant and fuera_servicio are never high together.

## Timing
- uso high at edge n: uso_count shows the new value after edge n.
  - At the limit, estado=ALERTA and alerta_mant=1 after the same edge n.
- ack_mant high at edge n while in ALERTA:
  - After edge n: estado=MANTENIMIENTO, mant_enable=1, mant_data=mant_count as sampled at edge n.
  - The register loads mant_data+1 at edge n+1.
  - After edge n+1: estado=OPERANDO or FUERA_SERVICIO, mant_enable=0.
- Alert-to-enable latency is 1 cycle after ack. The ALERTA dwell time is unbounded (waits for ack).
- Reset asserted mid-MANTENIMIENTO:
  - All outputs return to reset values after that edge.
  - The downstream register shares the reset and also clears, so no partial increment remains.
- USO_LIMITE=1: the first uso in OPERANDO goes straight to ALERTA with uso_count=1.

## Test plan
- **Count to alert:** reset, then 10 uso pulses with USO_LIMITE=10 -> uso_count steps 1..10; estado=1 and alerta_mant=1 after the 10th pulse; an 11th pulse leaves uso_count=10.
- **Maintenance handshake:**
  - Stimulus: in ALERTA, mant_count=3, ack_mant for 1 cycle.
  - Required: the next cycle shows mant_enable=1, mant_data=3, estado=2; the following cycle shows mant_enable=0, estado=0, uso_count=0, and the register holds 4.
- **Budget exhaustion:** MANT_MAX=5, mant_count=4 at ack -> the cycle after MANTENIMIENTO shows estado=3, fuera_servicio=1; further uso/ack pulses leave all outputs unchanged until reset.
- **Simultaneous and ignored inputs:**
  - uso and ack_mant high together in ALERTA -> MANTENIMIENTO entered, uso_count stays 10.
  - ack_mant in OPERANDO -> no state change, mant_enable stays 0.
- **Reset mid-operation:** reset asserted during MANTENIMIENTO -> next cycle estado=0, all outputs 0, register=0. Reset asserted with uso=1 at uso_count=5 -> uso_count=0.
- **Full loop:** 5 complete use/ack cycles with MANT_MAX=5 from reset -> the register reads 1..5 and fuera_servicio rises exactly after the 5th MANTENIMIENTO cycle.
